mar_burst: RTL and testbench
============================

// Module: mar_burst
// PURPOSE
//  Parametrised memory address register with burst sequencing, successor to the single-load MAR.
//  Keeps the PC / ALU / increment load paths and adds an LDM/STM-style multi-beat address generator.
//  Four ARM addressing modes are supported: IA, IB, DA, DB.
//  Sits between the datapath (PC, ALU_bus) and the memory interface, with a REQ/ACK handshake.
//  Supplies the base-writeback value to the register file.
// PARAMETERS
//  ADDR_W  32  address/data width; all address arithmetic is modulo 2^ADDR_W
//  LEN_W   5   width of BURST_LEN; max burst = 2^LEN_W-1 beats (16 regs fit)
//  STRIDE  4   byte step per beat; power of two
// PORTS
//  CLK        in   1       clock, rising edge
//  RESET_N    in   1       asynchronous, active-low reset
//  LATCH_MAR  in   1       single load strobe, accepted only when BUSY=0
//  MARMUX1    in   1       single-load source: PC
//  MARMUX2    in   1       single-load source: ALU_bus (priority over MARMUX1)
//  PC         in   ADDR_W  program counter
//  ALU_bus    in   ADDR_W  ALU result; also the burst base
//  BURST_START in  1       start burst, accepted only when BUSY=0; wins over LATCH_MAR
//  BURST_LEN  in   LEN_W   beat count, sampled with BURST_START
//  MODE       in   2       {P,U}: 00=DA, 01=IA, 10=DB, 11=IB; sampled with BURST_START
//  MEM_ACK    in   1       memory accepted current beat
//  address    out  ADDR_W  current MAR value
//  MEM_REQ    out  1       beat request; held with address until MEM_ACK
//  BEAT       out  LEN_W   index of current beat (0..len-1), lowest address = beat 0
//  BUSY       out  1       high in any state other than IDLE
//  DONE       out  1       one-cycle pulse at burst end
//  WB_ADDR    out  ADDR_W  base writeback value, valid from the cycle after BURST_START
// BEHAVIOUR
//  Reset (async, immediate, including mid-burst):
//   - outputs: address=0, MEM_REQ=0, BEAT=0, BUSY=0, DONE=0, WB_ADDR=0
//   - state=IDLE; no pending beat survives
//  Single load (IDLE, LATCH_MAR=1, BURST_START=0), at the edge:
//   - MARMUX2=1: address <= ALU_bus
//   - else MARMUX1=1: address <= PC
//   - else: address <= address+STRIDE
//   - state stays IDLE
//  Burst start (IDLE, BURST_START=1); n=BURST_LEN, b=ALU_bus, B=n*STRIDE (shift, zero-extended to ADDR_W):
//   - first address: IA b; IB b+STRIDE; DA b-B+STRIDE; DB b-B
//   - WB_ADDR <= b+B if U=1, b-B if U=0
//   - BEAT <= 0; state -> ISSUE if n>0, -> DONE if n==0 (address unchanged, no MEM_REQ)
//  States:
//   - IDLE: ready for a single load or burst start
//   - ISSUE: MEM_REQ=1; address and BEAT held stable until MEM_ACK is sampled high
//     - ACK, not last beat: address += STRIDE, BEAT += 1, stay ISSUE; REQ stays high (back-to-back)
//     - ACK on last beat (BEAT==n-1): address += STRIDE, MEM_REQ -> 0, state -> DONE
//   - DONE: DONE=1 for exactly one cycle, BUSY=1, then -> IDLE
//  Ignored/sampled inputs:
//   - MEM_ACK is ignored outside ISSUE
//   - LATCH_MAR and BURST_START are ignored while BUSY=1; no queueing
//   - BURST_LEN and MODE are sampled only at the start edge
//  Wrap: all sums truncate to ADDR_W bits; no error is flagged.
//  Latency: first MEM_REQ appears 1 cycle after the start edge. Burst of n beats with ACK every
//   cycle: start edge to DONE pulse = n+1 cycles.
// TESTING
//  1 Reset: RESET_N=0 at any time -> address=0, MEM_REQ=0, BUSY=0, DONE=0, WB_ADDR=0 without a clock edge.
//  2 Single loads:
//    - PC=0x1111, ALU_bus=0x2222, MARMUX1=1, LATCH -> 0x1111
//    - MARMUX2=1 as well -> 0x2222
//    - both 0 -> 0x2226, then 0x222A
//  3 IA burst: base 0x1000, len 3, MEM_ACK tied high -> address 0x1000,0x1004,0x1008 on
//    successive REQ cycles; BEAT 0,1,2; DONE pulses once; WB_ADDR=0x100C.
//  4 DB burst: base 0x1000, len 4, ACK 2 cycles after each REQ -> 0x0FF0,0x0FF4,0x0FF8,0x0FFC,
//    each held stable while waiting; WB_ADDR=0x0FF0; LATCH_MAR mid-burst has no effect.
//  5 Edge cases:
//    - len 0 -> no MEM_REQ, DONE 1 cycle after start, address unchanged
//    - DA base 0x0, len 2 -> 0xFFFFFFFC then 0x00000000; WB_ADDR=0xFFFFFFF8
//  6 Reset mid-burst: assert after beat 0 ACK of a len 4 burst -> MEM_REQ drops immediately,
//    IDLE; a following PC single load returns the PC value.

Source files
------------

// File: rtl/mar_burst_if.sv
// Datapath/memory bundle for the burst-capable memory address register.
// The master drives the datapath inputs and the DUT (slave) drives the address side.
interface mar_burst_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 5
);
    logic              LATCH_MAR;
    logic              MARMUX1;
    logic              MARMUX2;
    logic [ADDR_W-1:0] PC;
    logic [ADDR_W-1:0] ALU_bus;
    logic              BURST_START;
    logic [LEN_W-1:0]  BURST_LEN;
    logic [1:0]        MODE;
    logic              MEM_ACK;
    logic [ADDR_W-1:0] address;
    logic              MEM_REQ;
    logic [LEN_W-1:0]  BEAT;
    logic              BUSY;
    logic              DONE;
    logic [ADDR_W-1:0] WB_ADDR;

    modport master (
        output LATCH_MAR, MARMUX1, MARMUX2,
        output PC, ALU_bus,
        output BURST_START, BURST_LEN, MODE,
        output MEM_ACK,
        input  address, MEM_REQ, BEAT,
        input  BUSY, DONE, WB_ADDR
    );

    modport slave (
        input  LATCH_MAR, MARMUX1, MARMUX2,
        input  PC, ALU_bus,
        input  BURST_START, BURST_LEN, MODE,
        input  MEM_ACK,
        output address, MEM_REQ, BEAT,
        output BUSY, DONE, WB_ADDR
    );
endinterface

// File: rtl/mar_burst.sv
// Memory address register with single loads and LDM/STM-style bursts.
// Modes IA/IB/DA/DB; beat 0 is always the lowest address.
module mar_burst #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 5,
    parameter int STRIDE = 4
) (
    input logic      CLK,
    input logic      RESET_N,
    mar_burst_if.slave bus
);
    localparam int SH = $clog2(STRIDE);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [ADDR_W-1:0] wb, wb_n;
    logic [LEN_W-1:0]  beat, beat_n;
    logic [LEN_W-1:0]  len, len_n;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] first;

    assign span = ADDR_W'(bus.BURST_LEN) << SH;

    // MODE is {P,U}: U selects up/down, P pre- vs post-step
    always_comb begin
        first = bus.ALU_bus;
        unique case (bus.MODE)
            2'b00: first = bus.ALU_bus - span + STEP;
            2'b01: first = bus.ALU_bus;
            2'b10: first = bus.ALU_bus - span;
            2'b11: first = bus.ALU_bus + STEP;
            default: first = bus.ALU_bus;
        endcase
    end

    always_comb begin
        state_n = state;
        addr_n  = addr;
        wb_n    = wb;
        beat_n  = beat;
        len_n   = len;
        unique case (state)
            S_IDLE: begin
                if (bus.BURST_START) begin
                    len_n  = bus.BURST_LEN;
                    beat_n = '0;
                    wb_n   = bus.MODE[0] ? bus.ALU_bus + span
                                         : bus.ALU_bus - span;
                    if (bus.BURST_LEN != '0) begin
                        state_n = S_ISSUE;
                        addr_n  = first;
                    end else begin
                        state_n = S_DONE;
                    end
                end else if (bus.LATCH_MAR) begin
                    priority case (1'b1)
                        bus.MARMUX2: addr_n = bus.ALU_bus;
                        bus.MARMUX1: addr_n = bus.PC;
                        default:     addr_n = addr + STEP;
                    endcase
                end
            end
            S_ISSUE: begin
                if (bus.MEM_ACK) begin
                    addr_n = addr + STEP;
                    if (beat == len - LEN_W'(1)) begin
                        state_n = S_DONE;
                    end else begin
                        beat_n = beat + LEN_W'(1);
                    end
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            addr  <= '0;
            wb    <= '0;
            beat  <= '0;
            len   <= '0;
        end else begin
            state <= state_n;
            addr  <= addr_n;
            wb    <= wb_n;
            beat  <= beat_n;
            len   <= len_n;
        end
    end

    assign bus.address = addr;
    assign bus.WB_ADDR = wb;
    assign bus.BEAT    = beat;
    assign bus.MEM_REQ = (state == S_ISSUE);
    assign bus.BUSY    = (state != S_IDLE);
    assign bus.DONE    = (state == S_DONE);
endmodule

// File: tb/tb_mar_burst.sv
// Directed bench for mar_burst: single loads, four burst modes,
// zero-length and wrapping bursts, asynchronous reset.
module tb_mar_burst;
    logic CLK = 1'b0;
    logic RESET_N = 1'b1;
    int   npass = 0;
    int   ntot  = 0;

    mar_burst_if #(.ADDR_W(32), .LEN_W(5)) bus ();

    mar_burst #(.ADDR_W(32), .LEN_W(5), .STRIDE(4)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h",
                      tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [31:0] base, input logic [4:0] n,
                         input logic [1:0] m);
        bus.ALU_bus     = base;
        bus.BURST_LEN   = n;
        bus.MODE        = m;
        bus.BURST_START = 1'b1;
        tick();
        bus.BURST_START = 1'b0;
    endtask

    initial begin
        bus.LATCH_MAR   = 1'b0;
        bus.MARMUX1     = 1'b0;
        bus.MARMUX2     = 1'b0;
        bus.PC          = '0;
        bus.ALU_bus     = '0;
        bus.BURST_START = 1'b0;
        bus.BURST_LEN   = '0;
        bus.MODE        = 2'b01;
        bus.MEM_ACK     = 1'b0;

        #2 RESET_N = 1'b0;
        #1;
        chk("rst_addr", bus.address, 32'h0);
        chk("rst_req",  32'(bus.MEM_REQ), 32'h0);
        chk("rst_busy", 32'(bus.BUSY), 32'h0);
        chk("rst_done", 32'(bus.DONE), 32'h0);
        chk("rst_wb",   bus.WB_ADDR, 32'h0);
        chk("rst_beat", 32'(bus.BEAT), 32'h0);
        #4 RESET_N = 1'b1;

        bus.PC        = 32'h1111;
        bus.ALU_bus   = 32'h2222;
        bus.MARMUX1   = 1'b1;
        bus.LATCH_MAR = 1'b1;
        tick();
        chk("ld_pc", bus.address, 32'h1111);
        bus.MARMUX2 = 1'b1;
        tick();
        chk("ld_alu", bus.address, 32'h2222);
        bus.MARMUX1 = 1'b0;
        bus.MARMUX2 = 1'b0;
        tick();
        chk("ld_inc1", bus.address, 32'h2226);
        tick();
        chk("ld_inc2", bus.address, 32'h222A);
        chk("ld_busy", 32'(bus.BUSY), 32'h0);
        bus.LATCH_MAR = 1'b0;

        bus.MEM_ACK = 1'b1;
        start(32'h1000, 5'd3, 2'b01);
        chk("ia_wb", bus.WB_ADDR, 32'h100C);
        for (int k = 0; k < 3; k++) begin
            chk("ia_req",  32'(bus.MEM_REQ), 32'h1);
            chk("ia_addr", bus.address, 32'h1000 + 32'(4 * k));
            chk("ia_beat", 32'(bus.BEAT), 32'(k));
            chk("ia_nodone", 32'(bus.DONE), 32'h0);
            tick();
        end
        chk("ia_done", 32'(bus.DONE), 32'h1);
        chk("ia_reqlo", 32'(bus.MEM_REQ), 32'h0);
        chk("ia_dbusy", 32'(bus.BUSY), 32'h1);
        chk("ia_end", bus.address, 32'h100C);
        tick();
        chk("ia_done1", 32'(bus.DONE), 32'h0);
        chk("ia_idle", 32'(bus.BUSY), 32'h0);

        bus.MEM_ACK = 1'b0;
        start(32'h1000, 5'd4, 2'b10);
        chk("db_wb", bus.WB_ADDR, 32'h0FF0);
        for (int k = 0; k < 4; k++) begin
            chk("db_addr", bus.address, 32'h0FF0 + 32'(4 * k));
            chk("db_beat", 32'(bus.BEAT), 32'(k));
            bus.ALU_bus   = 32'hDEAD0000;
            bus.MARMUX2   = 1'b1;
            bus.LATCH_MAR = 1'b1;
            tick();
            chk("db_hold", bus.address, 32'h0FF0 + 32'(4 * k));
            chk("db_req",  32'(bus.MEM_REQ), 32'h1);
            bus.LATCH_MAR = 1'b0;
            bus.MARMUX2   = 1'b0;
            bus.MEM_ACK   = 1'b1;
            tick();
            bus.MEM_ACK = 1'b0;
        end
        chk("db_done", 32'(bus.DONE), 32'h1);
        chk("db_end", bus.address, 32'h1000);
        tick();
        chk("db_idle", 32'(bus.BUSY), 32'h0);
        chk("db_nolatch", bus.address, 32'h1000);

        bus.MEM_ACK = 1'b1;
        start(32'h5000, 5'd0, 2'b01);
        chk("z_done", 32'(bus.DONE), 32'h1);
        chk("z_req",  32'(bus.MEM_REQ), 32'h0);
        chk("z_busy", 32'(bus.BUSY), 32'h1);
        chk("z_addr", bus.address, 32'h1000);
        chk("z_wb",   bus.WB_ADDR, 32'h5000);
        tick();
        chk("z_idle", 32'(bus.BUSY), 32'h0);

        start(32'h0, 5'd2, 2'b00);
        chk("da_a0", bus.address, 32'hFFFFFFFC);
        chk("da_wb", bus.WB_ADDR, 32'hFFFFFFF8);
        tick();
        chk("da_a1", bus.address, 32'h0);
        chk("da_b1", 32'(bus.BEAT), 32'h1);
        tick();
        chk("da_done", 32'(bus.DONE), 32'h1);
        chk("da_end", bus.address, 32'h4);
        tick();

        start(32'h2000, 5'd4, 2'b11);
        chk("ib_a0", bus.address, 32'h2004);
        chk("ib_wb", bus.WB_ADDR, 32'h2010);
        tick();
        chk("ib_a1", bus.address, 32'h2008);
        #1 RESET_N = 1'b0;
        #1;
        chk("mr_req",  32'(bus.MEM_REQ), 32'h0);
        chk("mr_busy", 32'(bus.BUSY), 32'h0);
        chk("mr_addr", bus.address, 32'h0);
        chk("mr_wb",   bus.WB_ADDR, 32'h0);
        chk("mr_beat", 32'(bus.BEAT), 32'h0);
        #1 RESET_N = 1'b1;
        bus.MEM_ACK   = 1'b0;
        bus.PC        = 32'h3333;
        bus.MARMUX1   = 1'b1;
        bus.LATCH_MAR = 1'b1;
        tick();
        chk("mr_ldpc", bus.address, 32'h3333);
        chk("mr_idle", 32'(bus.BUSY), 32'h0);
        bus.LATCH_MAR = 1'b0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
